// File: rtl/led_axi_regfile.sv
// rtl/led_axi_regfile.sv - AXI4-Lite slave register file for the LED peripheral
//
// Purpose:
//    Terminates AXI4-Lite write and read channels and owns eight 32-bit
//    software registers r0..r7 that feed the LED control stage; r0[3:0]
//    drives the LEDs. Reads go through the LED control stage: the latched
//    read address is presented on axi_araddr and the stage's combinational
//    readback word (reg_out) is captured into rdata one cycle later.
//
// Ports:
//    clk, reset            sole clock, synchronous active-high reset
//    s_axi_aw*             write address channel
//    s_axi_w*              write data channel with byte strobes
//    s_axi_b*              write response channel (always OKAY)
//    s_axi_ar*             read address channel
//    s_axi_r*              read data channel (always OKAY)
//    r0..r7                register contents to the LED control stage
//    axi_araddr            latched read address to the LED control stage
//    reg_out               readback word selected by the LED control stage

module led_axi_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int ADDR_LSB           = 2
) (
   input  logic                              clk,
   input  logic                              reset,

   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,

   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,

   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,

   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,

   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,

   output logic [C_S_AXI_DATA_WIDTH-1:0]     r0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r3,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r4,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r5,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r6,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     r7,

   output logic [C_S_AXI_ADDR_WIDTH-1:0]     axi_araddr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     reg_out
);

   localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int NUM_REGS  = 1 << IDX_W;
   localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ADDR = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   // ------------------------------------------------------------------
   // Write path state
   // ------------------------------------------------------------------
   logic                            aw_held_q, aw_held_d;
   logic                            w_held_q,  w_held_d;
   logic [IDX_W-1:0]                aw_idx_q,  aw_idx_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [NUM_BYTES-1:0]            wstrb_q,   wstrb_d;
   logic                            bvalid_q,  bvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   // ------------------------------------------------------------------
   // Read path state
   // ------------------------------------------------------------------
   logic [1:0]                      rstate_q, rstate_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q,  rdata_d;
   logic                            rvalid_q, rvalid_d;

   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic commit;

   // Byte-offset bits of the write address carry no information here.
   logic unused_awaddr_lsbs;
   assign unused_awaddr_lsbs = ^s_axi_awaddr[ADDR_LSB-1:0];

   // Readies are gated by reset so nothing is accepted on a reset edge.
   // New AW/W are blocked while a B response is outstanding.
   assign s_axi_awready = !aw_held_q && !bvalid_q && !reset;
   assign s_axi_wready  = !w_held_q  && !bvalid_q && !reset;
   assign s_axi_arready = (rstate_q == R_IDLE) && !reset;

   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid  && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;

   // Commit happens the cycle after both halves are held, so the register
   // update and bvalid appear together one edge after the later handshake.
   assign commit = aw_held_q && w_held_q;

   // ------------------------------------------------------------------
   // Write next-state
   // ------------------------------------------------------------------
   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_idx_d  = aw_idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      regs_d    = regs_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end

      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axi_wdata;
         wstrb_d  = s_axi_wstrb;
      end

      if (commit) begin
         // wstrb of zero still commits and responds; the register is untouched.
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wstrb_q[b]) begin
               regs_d[aw_idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
         end
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Read next-state
   // ------------------------------------------------------------------
   always_comb begin
      rstate_d = rstate_q;
      araddr_d = araddr_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;

      case (rstate_q)
         R_IDLE: begin
            if (ar_hs) begin
               araddr_d = s_axi_araddr;
               rstate_d = R_ADDR;
            end
         end
         R_ADDR: begin
            // reg_out reflects the registered contents, so a write committing
            // on this same edge is not seen: rdata gets the pre-write value.
            rdata_d  = reg_out;
            rvalid_d = 1'b1;
            rstate_d = R_DATA;
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
         default: begin
            rvalid_d = 1'b0;
            rstate_d = R_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         rstate_q  <= R_IDLE;
         araddr_q  <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_idx_q  <= aw_idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         regs_q    <= regs_d;
         rstate_q  <= rstate_d;
         araddr_q  <= araddr_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign s_axi_bresp  = 2'b00;
   assign s_axi_bvalid = bvalid_q;
   assign s_axi_rresp  = 2'b00;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rvalid = rvalid_q;
   assign axi_araddr   = araddr_q;

   assign r0 = regs_q[0];
   assign r1 = regs_q[1];
   assign r2 = regs_q[2];
   assign r3 = regs_q[3];
   assign r4 = regs_q[4];
   assign r5 = regs_q[5];
   assign r6 = regs_q[6];
   assign r7 = regs_q[7];

endmodule

// File: tb/tb_led_axi_regfile.sv
// tb/tb_led_axi_regfile.sv - directed self-checking bench for led_axi_regfile

module tb_led_axi_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [4:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [4:0]  axi_araddr;
   logic [31:0] reg_out;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Stand-in for the LED control stage readback mux.
   always_comb begin
      case (axi_araddr[4:2])
         3'd0:    reg_out = r0;
         3'd1:    reg_out = r1;
         3'd2:    reg_out = r2;
         3'd3:    reg_out = r3;
         3'd4:    reg_out = r4;
         3'd5:    reg_out = r5;
         3'd6:    reg_out = r6;
         default: reg_out = r7;
      endcase
   end

   led_axi_regfile dut (
      .clk           (clk),
      .reset         (reset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .r0            (r0),
      .r1            (r1),
      .r2            (r2),
      .r3            (r3),
      .r4            (r4),
      .r5            (r5),
      .r6            (r6),
      .r7            (r7),
      .axi_araddr    (axi_araddr),
      .reg_out       (reg_out)
   );

   // Advance past the next rising edge; all driving and sampling is done 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: AW+W same cycle from idle with bready high, then B handshake.
   task automatic write_word(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_readies got %b exp 000", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      tests_run++;
      if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
         tests_failed++; $display("FAIL reset_valids got %b exp 00", {s_axi_bvalid, s_axi_rvalid});
      end
      tests_run++;
      if ({r0, r1, r2, r3, r4, r5, r6, r7} !== 256'd0) begin
         tests_failed++; $display("FAIL reset_regs got nonzero exp all 0");
      end
      tests_run++;
      if ({axi_araddr, s_axi_rdata} !== 37'd0) begin
         tests_failed++; $display("FAIL reset_araddr_rdata got %h/%h exp 0/0", axi_araddr, s_axi_rdata);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         tests_failed++; $display("FAIL post_reset_readies got %b exp 111", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
   endtask

   task automatic test_basic_write();
      s_axi_bready = 1'b1;
      s_axi_awaddr = 5'h00; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h0000_000A; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tests_run++;
      if ({s_axi_bvalid, r0} !== {1'b0, 32'h0}) begin
         tests_failed++; $display("FAIL basic_pre_commit got bvalid=%b r0=%h exp 0/0", s_axi_bvalid, r0);
      end
      tick();
      tests_run++;
      if (r0 !== 32'h0000_000A) begin
         tests_failed++; $display("FAIL basic_r0 got %h exp 0000000a", r0);
      end
      tests_run++;
      if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
         tests_failed++; $display("FAIL basic_bresp got bvalid=%b bresp=%b exp 1/00", s_axi_bvalid, s_axi_bresp);
      end
      tests_run++;
      if (r0[3:0] !== 4'hA) begin
         tests_failed++; $display("FAIL basic_leds got %h exp a", r0[3:0]);
      end
      tick();
      tests_run++;
      if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
         tests_failed++; $display("FAIL basic_b_done got bvalid=%b awready=%b exp 0/1", s_axi_bvalid, s_axi_awready);
      end
   endtask

   task automatic test_split_write();
      s_axi_bready = 1'b1;
      s_axi_awaddr = 5'h0C; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tests_run++;
         if (s_axi_awready !== 1'b0) begin
            tests_failed++; $display("FAIL split_awready_c%0d got %b exp 0", c, s_axi_awready);
         end
         if (c == 3) begin
            s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'h5; s_axi_wvalid = 1'b1;
         end
         tick();
      end
      s_axi_wvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_bvalid, r3} !== {1'b1, 32'h00AD_00EF}) begin
         tests_failed++; $display("FAIL split_r3 got bvalid=%b r3=%h exp 1/00ad00ef", s_axi_bvalid, r3);
      end
      tick();
   endtask

   task automatic test_back_to_back_bready_hold();
      s_axi_bready = 1'b0;
      s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h1122_3344; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awaddr = 5'h10; s_axi_wdata = 32'h0000_0055;
      tick();
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
            tests_failed++; $display("FAIL hold_c%0d got bvalid,awready,wready=%b exp 100",
                                     c, {s_axi_bvalid, s_axi_awready, s_axi_wready});
         end
         tick();
      end
      s_axi_bready = 1'b1;
      tick();
      tests_run++;
      if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
         tests_failed++; $display("FAIL hold_release got %b exp 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
      end
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_bvalid, r4, r1} !== {1'b1, 32'h0000_0055, 32'h1122_3344}) begin
         tests_failed++; $display("FAIL hold_next_write got bvalid=%b r4=%h r1=%h exp 1/00000055/11223344",
                                  s_axi_bvalid, r4, r1);
      end
      tick();
   endtask

   task automatic test_read_stall();
      write_word(5'h14, 32'h1234_5678, 4'hF);
      s_axi_rready = 1'b0;
      s_axi_araddr = 5'h16; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      tests_run++;
      if ({axi_araddr, s_axi_rvalid, s_axi_arready} !== {5'h16, 2'b00}) begin
         tests_failed++; $display("FAIL read_addr got araddr=%h rvalid=%b arready=%b exp 16/0/0",
                                  axi_araddr, s_axi_rvalid, s_axi_arready);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {3'b100, 32'h1234_5678}) begin
            tests_failed++; $display("FAIL read_stall_c%0d got rvalid=%b rresp=%b rdata=%h exp 1/00/12345678",
                                     c, s_axi_rvalid, s_axi_rresp, s_axi_rdata);
         end
         if (c < 3) tick();
      end
      s_axi_rready = 1'b1;
      tick();
      tests_run++;
      if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
         tests_failed++; $display("FAIL read_done got rvalid=%b arready=%b exp 0/1", s_axi_rvalid, s_axi_arready);
      end
   endtask

   task automatic test_read_write_collision();
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      s_axi_awaddr = 5'h08; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_araddr = 5'h08; s_axi_arvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_rvalid, s_axi_rdata, r2} !== {1'b1, 32'h0, 32'hFFFF_FFFF}) begin
         tests_failed++; $display("FAIL collide got rvalid=%b rdata=%h r2=%h exp 1/00000000/ffffffff",
                                  s_axi_rvalid, s_axi_rdata, r2);
      end
      tick();
      s_axi_araddr = 5'h08; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'hFFFF_FFFF}) begin
         tests_failed++; $display("FAIL collide_reread got rvalid=%b rdata=%h exp 1/ffffffff", s_axi_rvalid, s_axi_rdata);
      end
      tick();
   endtask

   task automatic test_wstrb_zero();
      s_axi_bready = 1'b0;
      s_axi_awaddr = 5'h0C; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_bvalid, r3} !== {1'b1, 32'h00AD_00EF}) begin
         tests_failed++; $display("FAIL wstrb0 got bvalid=%b r3=%h exp 1/00ad00ef", s_axi_bvalid, r3);
      end
      s_axi_bready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      s_axi_awaddr = 5'h18; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_araddr = 5'h00; s_axi_arvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      tick();
      tests_run++;
      if ({s_axi_bvalid, s_axi_rvalid, r6} !== {2'b11, 32'hCAFE_F00D}) begin
         tests_failed++; $display("FAIL mid_setup got bvalid=%b rvalid=%b r6=%h exp 1/1/cafef00d",
                                  s_axi_bvalid, s_axi_rvalid, r6);
      end
      reset = 1'b1;
      tick();
      tests_run++;
      if ({s_axi_bvalid, s_axi_rvalid, r0, r1, r2, r3, r4, r5, r6, r7} !== 258'd0) begin
         tests_failed++; $display("FAIL mid_reset got bvalid=%b rvalid=%b r6=%h exp 0/0/00000000",
                                  s_axi_bvalid, s_axi_rvalid, r6);
      end
      reset = 1'b0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests_run++;
         if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
            tests_failed++; $display("FAIL mid_no_resp_c%0d got bvalid=%b rvalid=%b exp 0/0", c, s_axi_bvalid, s_axi_rvalid);
         end
      end
      // An AW accepted before reset must be forgotten: a later lone W never commits.
      s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      s_axi_wdata = 32'h0000_0099; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({s_axi_bvalid, r1} !== {1'b0, 32'h0}) begin
         tests_failed++; $display("FAIL mid_aw_dropped got bvalid=%b r1=%h exp 0/00000000", s_axi_bvalid, r1);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_split_write();
      test_back_to_back_bready_hold();
      test_read_stall();
      test_read_write_collision();
      test_wstrb_zero();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got no finish exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_axi_regfile.md
# led_axi_regfile

AXI4-Lite slave front end that owns the eight 32-bit software registers of the LED peripheral. It terminates the write and read channels from the PS interconnect and drives r0–r7 to the downstream LED control stage; r0[3:0] drives the LEDs. It presents the latched read address to that stage and returns the stage's combinational readback word on the R channel.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 words
- ADDR_LSB, 2, lowest word-index bit; word index = addr[4:2]

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- s_axi_awaddr  input  5  write address
- s_axi_awvalid / s_axi_awready  input / output  1 / 1  AW handshake
- s_axi_wdata  input  32  write data
- s_axi_wstrb  input  4  byte enables
- s_axi_wvalid / s_axi_wready  input / output  1 / 1  W handshake
- s_axi_bresp  output  2  always 2'b00
- s_axi_bvalid / s_axi_bready  output / input  1 / 1  B handshake
- s_axi_araddr  input  5  read address
- s_axi_arvalid / s_axi_arready  input / output  1 / 1  AR handshake
- s_axi_rdata  output  32  read data
- s_axi_rresp  output  2  always 2'b00
- s_axi_rvalid / s_axi_rready  output / input  1 / 1  R handshake
- r0 … r7  output  32 each  register contents to LED control stage
- axi_araddr  output  5  latched read address to LED control stage
- reg_out  input  32  readback word selected by LED control stage

## Operation
- Write path holds flags aw_held, w_held plus latched awaddr, wdata, wstrb.
- awready = !aw_held && !bvalid && !reset; wready = !w_held && !bvalid && !reset (combinational from registered state).
- AW and W accepted independently, either order or same cycle; each latched on its handshake edge.
- Cycle after both flags are set: commit edge. Register addr[4:2] updated byte-wise (byte i written iff wstrb[i]); flags cleared; bvalid set.
- bvalid held until bvalid && bready edge; no new AW/W accepted while bvalid high.
- Read path states R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: arready = 1. On AR handshake latch araddr into axi_araddr → R_ADDR.
  - R_ADDR: arready = 0; at next edge capture reg_out into rdata, set rvalid → R_DATA.
  - R_DATA: rdata/rvalid stable until rready; on handshake edge clear rvalid → R_IDLE.
- Address bits [1:0] ignored; every address decodes, no SLVERR/DECERR.
- Read and write paths are independent and may run concurrently.

## Timing
- Reset (sampled at edge): r0–r7 = 0, axi_araddr = 0, rdata = 0, bvalid = rvalid = 0, flags clear, read state R_IDLE; all ready outputs 0 while reset high, 1 in first cycle after deassertion.
- Write latency: AW+W same edge k → register value and bvalid visible after edge k+1. AW at k, W at k+2 → commit at k+3.
- Minimum write throughput: one write per 3 cycles with bready tied high.
- Read latency: AR at edge k → rvalid after edge k+1; minimum 3 cycles per read with rready high.
- Simultaneous write commit and rdata capture on same register at the same edge: rdata gets the pre-write value.
- Reset asserted mid-transaction: all in-flight AW/W/AR dropped, no B or R response issued.
- wstrb = 0: commit and B response still occur, register unchanged.

## Test plan
- Reset then write 0x0000_000A to addr 0x00, wstrb 0xF, AW+W same cycle → r0 = 0x0000_000A one edge later, bvalid one cycle, bresp 00, LED bits = 4'hA.
- AW addr 0x0C at cycle 0, W 0xDEADBEEF wstrb 0x5 at cycle 3 → awready low cycles 1–3, r3 = 0x00AD00EF after commit.
- Hold bready low 5 cycles after write → bvalid stays high, awready/wready low throughout, next write accepted after B handshake.
- Preload r5 = 0x1234_5678, read addr 0x16 with rready low 4 cycles → axi_araddr = 0x16, rvalid after edge k+1, rdata stable 0x1234_5678 until rready.
- Write 0xFFFF_FFFF to r2 committing on the same edge read of r2 captures (r2 previously 0) → rdata = 0, subsequent read = 0xFFFF_FFFF.
- Assert reset while bvalid and rvalid high → both drop next edge, r0–r7 = 0, no response completes.
